// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the SRAM port arbiter: mem_control codes, FSM states,
// access owner and the idle/reset SRAM address.
package mem_port_arbiter_pkg;

    localparam logic [1:0] MC_IDLE  = 2'b00;
    localparam logic [1:0] MC_READ  = 2'b10;
    localparam logic [1:0] MC_WRITE = 2'b01;

    localparam logic [15:0] RESET_ADDR = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_DONE
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_MEM
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_ram_strobe_timer.sv
// Strobe-width counter: loads WAIT_CYCLES-1, counts down to zero, done at zero.
// Latency: done seen WAIT_CYCLES-1 decrements after load; no backpressure.
module ram_strobe_timer #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int CW = 4;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(WAIT_CYCLES - 1);
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and MEM-stage requests onto one SRAM (MEM first).
// Latency: grant to valid pulse 2+WAIT_CYCLES; losers stall until their own access completes.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              stall_if,
    input  logic [1:0]        mem_control,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_valid,
    output logic              stall_mem,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dout,
    output logic              ram_dout_en,
    input  logic [DATA_W-1:0] ram_din,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    state_t state;
    owner_t owner;
    logic   op_write;
    logic   mem_req;
    logic   timer_done;

    assign mem_req   = (mem_control == MC_READ) || (mem_control == MC_WRITE);
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = mem_req & ~mem_valid;

    ram_strobe_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (state == ST_SETUP),
        .dec  (state == ST_STROBE),
        .done (timer_done)
    );

    // Pin outputs are registered: each edge loads the values for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            owner       <= OWN_IF;
            op_write    <= 1'b0;
            ram_ce_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            ram_dout_en <= 1'b0;
            ram_addr    <= ADDR_W'(RESET_ADDR);
            ram_dout    <= '0;
            if_valid    <= 1'b0;
            mem_valid   <= 1'b0;
            if_rdata    <= '0;
            mem_rdata   <= '0;
        end else begin
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_req) begin
                        state       <= ST_SETUP;
                        owner       <= OWN_MEM;
                        op_write    <= (mem_control == MC_WRITE);
                        ram_addr    <= mem_addr;
                        ram_dout    <= mem_wdata;
                        ram_ce_n    <= 1'b0;
                        ram_dout_en <= (mem_control == MC_WRITE);
                    end else if (if_req) begin
                        state       <= ST_SETUP;
                        owner       <= OWN_IF;
                        op_write    <= 1'b0;
                        ram_addr    <= if_addr;
                        ram_ce_n    <= 1'b0;
                        ram_dout_en <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    state <= ST_STROBE;
                    if (op_write) begin
                        ram_we_n <= 1'b0;
                    end else begin
                        ram_oe_n <= 1'b0;
                    end
                end
                ST_STROBE: begin
                    if (timer_done) begin
                        state    <= ST_DONE;
                        ram_oe_n <= 1'b1;
                        ram_we_n <= 1'b1;
                        if (owner == OWN_IF) begin
                            if_valid <= 1'b1;
                            if_rdata <= ram_din;
                        end else begin
                            mem_valid <= 1'b1;
                            if (!op_write) begin
                                mem_rdata <= ram_din;
                            end
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    ram_ce_n    <= 1'b1;
                    ram_dout_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a cycle-numbered access model.
module tb_mem_port_arbiter;

    localparam int WC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_valid;
    logic        stall_if;
    logic [1:0]  mem_control;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic        stall_mem;
    logic [15:0] ram_addr;
    logic [15:0] ram_dout;
    logic        ram_dout_en;
    logic [15:0] ram_din;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    logic [15:0] ram_env [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .WAIT_CYCLES(WC),
        .ADDR_W     (16),
        .DATA_W     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_valid   (if_valid),
        .stall_if   (stall_if),
        .mem_control(mem_control),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .stall_mem  (stall_mem),
        .ram_addr   (ram_addr),
        .ram_dout   (ram_dout),
        .ram_dout_en(ram_dout_en),
        .ram_din    (ram_din),
        .ram_ce_n   (ram_ce_n),
        .ram_oe_n   (ram_oe_n),
        .ram_we_n   (ram_we_n)
    );

    function automatic logic [15:0] fill(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    function automatic logic [15:0] env_rd(input logic [15:0] a);
        return ram_env.exists(a) ? ram_env[a] : fill(a);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    // Asynchronous SRAM: read data presented well before the next rising edge, write while WE is low.
    always @(negedge clk) ram_din = env_rd(ram_addr);
    always @(posedge clk) begin
        if (!ram_ce_n && !ram_we_n && ram_dout_en) ram_env[ram_addr] = ram_dout;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Access timeline, cycle 0 = grant: SETUP at g+1, STROBE g+2..g+1+WC, DONE (valid) at g+2+WC.
    task automatic run_txn(input logic [1:0] mc, input logic [15:0] ma, input logic [15:0] md,
                           input logic ir, input logic [15:0] ia);
        bit mreq = (mc == 2'b10) || (mc == 2'b01);
        bit mwr  = (mc == 2'b01);
        int g_m = -100, g_i = -100, d_m, d_i, last;
        logic [15:0] exp_m, exp_i;
        if (mreq) g_m = 0;
        if (ir) g_i = mreq ? (3 + WC) : 0;
        d_m = g_m + 2 + WC;
        d_i = g_i + 2 + WC;
        last = 5;
        if (mreq && d_m + 1 > last) last = d_m + 1;
        if (ir && d_i + 1 > last) last = d_i + 1;
        exp_m = ref_rd(ma);
        if (mreq && mwr) ref_mem[ma] = md;
        exp_i = ref_rd(ia);

        mem_control = mc;
        mem_addr    = ma;
        mem_wdata   = md;
        if_req      = ir;
        if_addr     = ia;
        for (int k = 0; k <= last; k++) begin
            bit am, ai, sm, si;
            #1;
            am = mreq && k >= g_m + 1 && k <= d_m;
            ai = ir && k >= g_i + 1 && k <= d_i;
            sm = k >= g_m + 2 && k <= g_m + 1 + WC;
            si = k >= g_i + 2 && k <= g_i + 1 + WC;
            chk("ce_n", 32'(ram_ce_n), 32'(!(am || ai)));
            chk("oe_n", 32'(ram_oe_n), 32'(!((am && !mwr && sm) || (ai && si))));
            chk("we_n", 32'(ram_we_n), 32'(!(am && mwr && sm)));
            chk("dout_en", 32'(ram_dout_en), 32'(am && mwr));
            if (am) chk("addr_mem", 32'(ram_addr), 32'(ma));
            if (ai) chk("addr_if", 32'(ram_addr), 32'(ia));
            if (am && mwr) chk("dout", 32'(ram_dout), 32'(md));
            chk("mem_valid", 32'(mem_valid), 32'(mreq && k == d_m));
            chk("if_valid", 32'(if_valid), 32'(ir && k == d_i));
            chk("stall_mem", 32'(stall_mem), 32'(mreq && k < d_m));
            chk("stall_if", 32'(stall_if), 32'(ir && k < d_i));
            if (mreq && !mwr && k == d_m) chk("mem_rdata", 32'(mem_rdata), 32'(exp_m));
            if (ir && k == d_i) chk("if_rdata", 32'(if_rdata), 32'(exp_i));
            if (mreq && k == d_m) mem_control = 2'b00;
            if (ir && k == d_i) if_req = 1'b0;
            @(negedge clk);
        end
        mem_control = 2'b00;
        if (mreq && mwr) chk("ram_written", 32'(env_rd(ma)), 32'(md));
    endtask

    task automatic chk_reset_vals();
        chk("rst_ce_n", 32'(ram_ce_n), 32'(1));
        chk("rst_oe_n", 32'(ram_oe_n), 32'(1));
        chk("rst_we_n", 32'(ram_we_n), 32'(1));
        chk("rst_dout_en", 32'(ram_dout_en), 32'(0));
        chk("rst_addr", 32'(ram_addr), 32'h0000FFFF);
        chk("rst_dout", 32'(ram_dout), 32'(0));
        chk("rst_if_valid", 32'(if_valid), 32'(0));
        chk("rst_mem_valid", 32'(mem_valid), 32'(0));
        chk("rst_if_rdata", 32'(if_rdata), 32'(0));
        chk("rst_mem_rdata", 32'(mem_rdata), 32'(0));
    endtask

    initial begin
        logic [1:0]  mc;
        logic [15:0] ma, md, ia;
        logic        ir;

        rst         = 1'b1;
        if_req      = 1'b0;
        if_addr     = '0;
        mem_control = 2'b00;
        mem_addr    = '0;
        mem_wdata   = '0;
        ram_env[16'h0010] = 16'h4801;
        ref_mem[16'h0010] = 16'h4801;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals();
        chk("rst_stall_if", 32'(stall_if), 32'(0));
        chk("rst_stall_mem", 32'(stall_mem), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        run_txn(2'b00, 16'h0000, 16'h0000, 1'b1, 16'h0010);
        run_txn(2'b01, 16'h8000, 16'hBEEF, 1'b0, 16'h0000);
        run_txn(2'b10, 16'h8000, 16'h0000, 1'b1, 16'h0020);
        run_txn(2'b11, 16'h1111, 16'h2222, 1'b0, 16'h0000);
        run_txn(2'b01, 16'hFFFF, 16'h1357, 1'b0, 16'h0000);
        run_txn(2'b10, 16'hFFFF, 16'h0000, 1'b1, 16'hFFFF);

        // Reset during the first STROBE cycle of a write.
        mem_control = 2'b01;
        mem_addr    = 16'h1234;
        mem_wdata   = 16'hA5A5;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        ref_mem[16'h1234] = 16'hA5A5;
        @(negedge clk);
        rst         = 1'b0;
        mem_control = 2'b00;
        #1;
        chk_reset_vals();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("post_rst_mem_valid", 32'(mem_valid), 32'(0));
            chk("post_rst_ce_n", 32'(ram_ce_n), 32'(1));
        end
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       mc = 2'b00;
                1:       mc = 2'b10;
                2:       mc = 2'b01;
                default: mc = 2'b11;
            endcase
            ma = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom_range(0, 31));
            ia = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom_range(0, 31));
            md = 16'($urandom);
            ir = 1'($urandom_range(0, 1));
            run_txn(mc, ma, md, ir, ia);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
